vga_sync_gen: RTL and testbench

- Generates VGA 640x480@60 Hz raster timing from the 100 MHz system clock.
- Produces the pixel coordinates (x, y) consumed by the pointer/overlay logic and pixel colour mux.
- Also produces hsync/vsync to the connector, plus a blank flag and a pixel-enable tick for downstream registered stages.
- Sits directly upstream of every pixel-generation block in the display path.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/pixel_tick_gen.sv | 40 ++++
 rtl/vga_sync_gen.sv | 103 ++++++++++
 tb/tb_vga_sync_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | vga_pkg
// | Default 640x480@60 raster geometry, sync windows and coordinate types.
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
package vga_pkg;

  localparam int c_coord_w   = 10;

  localparam int c_h_visible = 640;
  localparam int c_h_front   = 16;
  localparam int c_h_sync    = 96;
  localparam int c_h_back    = 48;
  localparam int c_v_visible = 480;
  localparam int c_v_front   = 10;
  localparam int c_v_sync    = 2;
  localparam int c_v_back    = 33;

  localparam int c_h_total   = c_h_visible + c_h_front + c_h_sync + c_h_back;
  localparam int c_v_total   = c_v_visible + c_v_front + c_v_sync + c_v_back;

  localparam int c_hsync_start = c_h_visible + c_h_front;
  localparam int c_hsync_end   = c_hsync_start + c_h_sync - 1;
  localparam int c_vsync_start = c_v_visible + c_v_front;
  localparam int c_vsync_end   = c_vsync_start + c_v_sync - 1;

  // Screen centre, used by overlay blocks to position pointers.
  localparam int c_centre_x  = c_h_visible / 2;
  localparam int c_centre_y  = c_v_visible / 2;

  typedef logic [c_coord_w-1:0] coord_t;

  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | pixel_tick_gen
// | Clock-enable divider: one-clk tick every CLK_DIV system clocks.
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  generate
    if (CLK_DIV == 1) begin : g_div1
      // Every clock is a pixel clock; held low only while reset is asserted.
      assign tick = ~reset;
    end else begin : g_divn
      localparam int              c_w    = $clog2(CLK_DIV);
      localparam logic [c_w-1:0]  c_last = c_w'(CLK_DIV - 1);

      logic [c_w-1:0] r_div_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_div_cnt <= '0;
        end else if (r_div_cnt == c_last) begin
          r_div_cnt <= '0;
        end else begin
          r_div_cnt <= r_div_cnt + c_w'(1);
        end
      end

      assign tick = (r_div_cnt == c_last);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | vga_sync_gen
// | VGA raster timing: pixel tick, x/y counters, blank, hsync/vsync, frame pulse.
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV     = 4,
  parameter int   H_VISIBLE   = c_h_visible,
  parameter int   H_FRONT     = c_h_front,
  parameter int   H_SYNC      = c_h_sync,
  parameter int   H_BACK      = c_h_back,
  parameter int   V_VISIBLE   = c_v_visible,
  parameter int   V_FRONT     = c_v_front,
  parameter int   V_SYNC      = c_v_sync,
  parameter int   V_BACK      = c_v_back,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 pix_tick,
  output logic [c_coord_w-1:0] x,
  output logic [c_coord_w-1:0] y,
  output logic                 blank,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_start
);

  localparam int c_h_last = H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1;
  localparam int c_v_last = V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1;
  localparam int c_hs_lo  = H_VISIBLE + H_FRONT;
  localparam int c_hs_hi  = c_hs_lo + H_SYNC - 1;
  localparam int c_vs_lo  = V_VISIBLE + V_FRONT;
  localparam int c_vs_hi  = c_vs_lo + V_SYNC - 1;

  logic   w_tick;
  logic   w_x_wrap;
  logic   w_y_wrap;
  coord_t w_x_next;
  coord_t w_y_next;
  coord_t r_x;
  coord_t r_y;
  logic   r_blank;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_frame_start;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  always_comb begin
    w_x_wrap = (r_x == coord_t'(c_h_last));
    w_y_wrap = (r_y == coord_t'(c_v_last));
    w_x_next = w_x_wrap ? '0 : r_x + coord_t'(1);
    w_y_next = r_y;
    if (w_x_wrap) begin
      w_y_next = w_y_wrap ? '0 : r_y + coord_t'(1);
    end
  end

  // Flags are decoded from the next coordinates so they land on the same
  // edge as x/y and never lag the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x           <= '0;
      r_y           <= '0;
      r_blank       <= 1'b0;
      r_hsync       <= ~SYNC_ACTIVE;
      r_vsync       <= ~SYNC_ACTIVE;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_tick) begin
        r_x           <= w_x_next;
        r_y           <= w_y_next;
        r_blank       <= (w_x_next >= coord_t'(H_VISIBLE)) || (w_y_next >= coord_t'(V_VISIBLE));
        r_hsync       <= in_window(w_x_next, coord_t'(c_hs_lo), coord_t'(c_hs_hi))
                         ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        r_vsync       <= in_window(w_y_next, coord_t'(c_vs_lo), coord_t'(c_vs_hi))
                         ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        r_frame_start <= w_x_wrap && w_y_wrap;
      end
    end
  end

  assign pix_tick    = w_tick;
  assign x           = r_x;
  assign y           = r_y;
  assign blank       = r_blank;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_vga_sync_gen
// | Self-checking bench: reduced-geometry raster, CLK_DIV=4 and CLK_DIV=1 copies.
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
module tb_vga_sync_gen;

  localparam int HV = 20, HF = 4, HS = 6, HB = 5;
  localparam int VV = 12, VF = 3, VS = 2, VB = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int HS_LO = HV + HF, HS_HI = HV + HF + HS - 1;
  localparam int VS_LO = VV + VF, VS_HI = VV + VF + VS - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick4, blank4, hs4, vs4, fs4;
  logic       tick1, blank1, hs1, vs1, fs1;
  logic [9:0] x4, y4, x1, y1;
  logic [24:0] act4, act1, rst_exp;
  int         cyc;
  int         n_checks = 0;
  int         n_pass = 0;

  vga_sync_gen #(
    .CLK_DIV(4), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE(1'b0)
  ) u_div4 (
    .clk(clk), .reset(reset), .pix_tick(tick4), .x(x4), .y(y4), .blank(blank4),
    .hsync(hs4), .vsync(vs4), .frame_start(fs4)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE(1'b0)
  ) u_div1 (
    .clk(clk), .reset(reset), .pix_tick(tick1), .x(x1), .y(y1), .blank(blank1),
    .hsync(hs1), .vsync(vs1), .frame_start(fs1)
  );

  assign act4 = {x4, y4, tick4, blank4, hs4, vs4, fs4};
  assign act1 = {x1, y1, tick1, blank1, hs1, vs1, fs1};

  always #5 clk = ~clk;

  // Clock edges seen since reset was last released.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
  end

  // Raster position is simply (pixel periods elapsed) mod frame size.
  function automatic logic [24:0] model(input int n, input int d);
    int t, pos, mx, my;
    logic tk, fs, bl, hs, vs;
    t   = n / d;
    pos = t % FRAME;
    mx  = pos % HT;
    my  = pos / HT;
    tk  = (d == 1) ? 1'b1 : ((n % d) == d - 1);
    fs  = (t > 0) && (pos == 0) && ((n % d) == 0);
    bl  = (mx >= HV) || (my >= VV);
    hs  = !((mx >= HS_LO) && (mx <= HS_HI));
    vs  = !((my >= VS_LO) && (my <= VS_HI));
    return {10'(mx), 10'(my), tk, bl, hs, vs, fs};
  endfunction

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if (act4 !== rst_exp) $display("FAIL reset_state_div4 got=%h exp=%h", act4, rst_exp);
    else n_pass++;
    n_checks++;
    if (act1 !== rst_exp) $display("FAIL reset_state_div1 got=%h exp=%h", act1, rst_exp);
    else n_pass++;
  endtask

  task automatic test_divider;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (act4 !== model(cyc, 4)) $display("FAIL divider_div4 cyc=%0d got=%h exp=%h", cyc, act4, model(cyc, 4));
      else n_pass++;
      n_checks++;
      if (act1 !== model(cyc, 1)) $display("FAIL divider_div1 cyc=%0d got=%h exp=%h", cyc, act1, model(cyc, 1));
      else n_pass++;
      if (cyc == 4 || cyc == 8) begin
        n_checks++;
        if (x4 !== 10'(cyc / 4)) $display("FAIL first_ticks_x cyc=%0d got=%0d exp=%0d", cyc, x4, cyc / 4);
        else n_pass++;
      end
    end
  endtask

  task automatic test_line;
    int low4 = 0, blk4 = 0, low1 = 0;
    for (int i = 0; i < HT * 4; i++) begin
      @(negedge clk);
      if (!hs4) low4++;
      if (blank4) blk4++;
      if (i < HT && !hs1) low1++;
      n_checks++;
      if (act4 !== model(cyc, 4)) $display("FAIL line_div4 cyc=%0d got=%h exp=%h", cyc, act4, model(cyc, 4));
      else n_pass++;
    end
    n_checks++;
    if (low4 !== HS * 4) $display("FAIL hsync_width_div4 got=%0d exp=%0d", low4, HS * 4);
    else n_pass++;
    n_checks++;
    if (blk4 !== (HT - HV) * 4) $display("FAIL hblank_width_div4 got=%0d exp=%0d", blk4, (HT - HV) * 4);
    else n_pass++;
    n_checks++;
    if (low1 !== HS) $display("FAIL hsync_width_div1 got=%0d exp=%0d", low1, HS);
    else n_pass++;
  endtask

  task automatic test_frame_wrap;
    int p4[$];
    int p1[$];
    int budget = 3 * FRAME * 4 + 16;
    while ((p4.size() < 2 || p1.size() < 3) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (fs4) p4.push_back(cyc);
      if (fs1) p1.push_back(cyc);
      n_checks++;
      if (act4 !== model(cyc, 4) || act1 !== model(cyc, 1))
        $display("FAIL frame_run cyc=%0d got4=%h exp4=%h got1=%h exp1=%h",
                 cyc, act4, model(cyc, 4), act1, model(cyc, 1));
      else n_pass++;
    end
    n_checks++;
    if (p4.size() < 2) $display("FAIL frame_period_div4 pulses=%0d exp=2 (timeout)", p4.size());
    else if (p4[1] - p4[0] !== FRAME * 4)
      $display("FAIL frame_period_div4 got=%0d exp=%0d", p4[1] - p4[0], FRAME * 4);
    else n_pass++;
    n_checks++;
    if (p1.size() < 3) $display("FAIL frame_period_div1 pulses=%0d exp=3 (timeout)", p1.size());
    else if (p1[2] - p1[1] !== FRAME)
      $display("FAIL frame_period_div1 got=%0d exp=%0d", p1[2] - p1[1], FRAME);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    for (int k = 0; k < 4; k++) begin
      int run = $urandom_range(FRAME * 4 - 1, 50);
      for (int i = 0; i < run; i++) begin
        @(negedge clk);
        n_checks++;
        if (act4 !== model(cyc, 4) || act1 !== model(cyc, 1))
          $display("FAIL random_run cyc=%0d got4=%h exp4=%h got1=%h exp1=%h",
                   cyc, act4, model(cyc, 4), act1, model(cyc, 1));
        else n_pass++;
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (act4 !== rst_exp) $display("FAIL async_reset_div4 got=%h exp=%h", act4, rst_exp);
      else n_pass++;
      n_checks++;
      if (act1 !== rst_exp) $display("FAIL async_reset_div1 got=%h exp=%h", act1, rst_exp);
      else n_pass++;
      repeat ($urandom_range(3, 1)) @(negedge clk);
      reset = 1'b0;
    end
  endtask

  initial begin
    rst_exp = {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    test_reset();
    test_divider();
    test_line();
    test_frame_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
